// File: rtl/pcle_timer_ctrl.sv
// rtl/pcle_timer_ctrl.sv - timer sequencer: prescaled 8-bit up-counter with one-shot/periodic expiry and saturating tally
module pcle_timer_ctrl #(
    parameter int WIDTH  = 8,
    parameter int PRE_W  = 4,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              periodic,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [PRE_W-1:0]  prescale,
    input  logic              clr_stat,
    output logic [WIDTH-1:0]  count_q,
    output logic              busy,
    output logic              expire,
    output logic [STAT_W-1:0] exp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  MAX = '1;
    localparam logic [STAT_W-1:0] SAT = '1;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   shadow_load;
    logic [PRE_W-1:0]   shadow_pre;
    logic               shadow_per;
    logic [PRE_W-1:0]   pre_cnt, pre_nx;
    logic [WIDTH-1:0]   count_nx;
    logic [STAT_W-1:0]  exp_count_nx;
    logic               capture;
    logic               expire_nx;
    logic               tick;

    assign tick = (pre_cnt == shadow_pre);

    always_comb begin
        state_nx  = state;
        count_nx  = count_q;
        pre_nx    = pre_cnt;
        capture   = 1'b0;
        expire_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    capture  = 1'b1;
                    state_nx = ARM;
                end
            end
            ARM: begin
                // the load completes even when stop aborts the arm
                count_nx = shadow_load;
                pre_nx   = '0;
                state_nx = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (start) begin
                    capture  = 1'b1;
                    state_nx = ARM;
                end else begin
                    pre_nx = tick ? '0 : pre_cnt + PRE_W'(1);
                    if (tick) begin
                        if (count_q != MAX) begin
                            count_nx = count_q + WIDTH'(1);
                        end else begin
                            expire_nx = 1'b1;
                            if (shadow_per) begin
                                count_nx = shadow_load;
                            end else begin
                                state_nx = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // tally moves on the same edge that raises expire
    always_comb begin
        exp_count_nx = exp_count;
        if (clr_stat) begin
            exp_count_nx = '0;
        end else if (expire_nx && exp_count != SAT) begin
            exp_count_nx = exp_count + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count_q     <= '0;
            shadow_load <= '0;
            shadow_pre  <= '0;
            shadow_per  <= 1'b0;
            pre_cnt     <= '0;
            busy        <= 1'b0;
            expire      <= 1'b0;
            exp_count   <= '0;
        end else begin
            state     <= state_nx;
            count_q   <= count_nx;
            pre_cnt   <= pre_nx;
            busy      <= (state_nx != IDLE);
            expire    <= expire_nx;
            exp_count <= exp_count_nx;
            if (capture) begin
                shadow_load <= load_val;
                shadow_pre  <= prescale;
                shadow_per  <= periodic;
            end
        end
    end

endmodule

// File: tb/tb_pcle_timer_ctrl.sv
// tb/tb_pcle_timer_ctrl.sv - scoreboard bench for pcle_timer_ctrl against a formula-based timer model
module tb_pcle_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic [7:0] load_val = '0;
    logic [3:0] prescale = '0;
    logic       clr_stat = 1'b0;
    logic [7:0] count_q;
    logic       busy;
    logic       expire;
    logic [7:0] exp_count;

    pcle_timer_ctrl #(.WIDTH(8), .PRE_W(4), .STAT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .periodic(periodic),
        .load_val(load_val), .prescale(prescale), .clr_stat(clr_stat),
        .count_q(count_q), .busy(busy), .expire(expire), .exp_count(exp_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic       busy;
        logic       ex;
        logic [7:0] ec;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // model: a run is described by its captured L/P/mode and the RUN edges elapsed
    bit   m_arm = 0, m_run = 0, m_per = 0;
    int   m_l = 0, m_p = 0, m_k = 0, m_cnt = 0, m_exp = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit per,
                              input int l, input int p, input bit clr);
        bit ex;
        int span, tdiv;
        ex = 0;
        if (m_run) begin
            if (sp) begin
                m_run = 0;
            end else if (st) begin
                m_l = l; m_p = p; m_per = per;
                m_run = 0; m_arm = 1;
            end else begin
                m_k++;
                span = 256 - m_l;
                tdiv = m_p + 1;
                if (m_k % (span * tdiv) == 0) begin
                    ex = 1;
                    if (m_per) m_cnt = m_l;
                    else begin m_cnt = 255; m_run = 0; end
                end else begin
                    m_cnt = m_l + (m_k / tdiv) % span;
                end
            end
        end else if (m_arm) begin
            m_cnt = m_l;
            m_arm = 0;
            if (!sp) begin m_run = 1; m_k = 0; end
        end else if (st && !sp) begin
            m_l = l; m_p = p; m_per = per;
            m_arm = 1;
        end
        if (clr) m_exp = 0;
        else if (ex && m_exp < 255) m_exp++;
        exp_q.push_back('{cnt: 8'(m_cnt), busy: (m_run | m_arm), ex: ex, ec: 8'(m_exp)});
    endtask

    task automatic step(input bit st, input bit sp, input bit per,
                        input int l, input int p, input bit clr);
        @(negedge clk);
        reset = 1'b0; start = st; stop = sp; periodic = per;
        load_val = 8'(l); prescale = 4'(p); clr_stat = clr;
        model_edge(st, sp, per, l, p, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_count_q"}, count_q, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_expire"}, expire, 0);
        chk({tag, "_exp_count"}, exp_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 0; stop = 0; clr_stat = 0;
        #1;
        check_zero("async_reset");
        m_arm = 0; m_run = 0; m_per = 0; m_l = 0; m_p = 0; m_k = 0; m_cnt = 0; m_exp = 0;
        exp_q.push_back('0);
    endtask

    // monitor: outputs are presented every cycle; compare one expectation per edge
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (count_q !== e.cnt || busy !== e.busy || expire !== e.ex || exp_count !== e.ec) begin
                    n_err++;
                    $display("FAIL cycle_outputs @%0t: got cnt=%h busy=%b exp=%b ec=%0d, expected cnt=%h busy=%b exp=%b ec=%0d",
                             $time, count_q, busy, expire, exp_count, e.cnt, e.busy, e.ex, e.ec);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_st;
        int run_len;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset_state");

        // reset mid-run at count 0x40
        step(1, 0, 0, 8'h3C, 0, 0);
        idle(5);
        do_reset();
        idle(4);

        // one-shot from 0xFD, no prescale
        step(1, 0, 0, 8'hFD, 0, 0);
        idle(6);

        // periodic from 0xFE, prescale 2: saturate tally, then clear
        step(1, 0, 1, 8'hFE, 2, 0);
        idle(1810);
        step(0, 0, 0, 0, 0, 1);
        idle(8);
        step(0, 1, 0, 0, 0, 0);
        idle(2);

        // stop on the terminal-tick cycle
        step(1, 0, 0, 8'hFD, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0);
        idle(3);

        // start with stop in idle, then restart mid-run with a new load
        step(1, 1, 0, 8'h20, 0, 0);
        idle(2);
        step(1, 0, 1, 8'h80, 1, 0);
        idle(10);
        step(1, 0, 0, 8'h10, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0);

        // input changes mid-run do not affect the period
        step(1, 0, 1, 8'hF8, 1, 0);
        idle(40);
        step(0, 1, 0, 0, 0, 0);

        // randomized runs
        prev_st = 0;
        for (int r = 0; r < 40; r++) begin
            step(1, 0, 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(8'hC0, 8'hFF)),
                 int'($urandom_range(0, 3)), 0);
            prev_st = 1;
            run_len = int'($urandom_range(1, 80));
            for (int c = 0; c < run_len; c++) begin
                bit st, sp;
                st = !prev_st && ($urandom_range(0, 49) == 0);
                sp = ($urandom_range(0, 39) == 0);
                step(st, sp, 1'($urandom), int'($urandom_range(8'hE0, 8'hFF)),
                     int'($urandom_range(0, 15)), $urandom_range(0, 29) == 0);
                prev_st = st;
            end
            step(0, 0, 0, 0, 0, 0);
            prev_st = 0;
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
